mem_arb2: RTL and testbench
===========================

MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter p_opaq_bits, default 8, width of the opaque request/response tag passed through unchanged.
REQ-002 Parameter p_max_in_flight, default 4, maximum accepted-but-unanswered server requests; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 c0_req_val / c1_req_val  input  1  client request valid; client 0 = instruction side, client 1 = data side.
REQ-006 c0_req_rdy / c1_req_rdy  output  1  client request accepted this cycle when val&rdy.
REQ-007 c0_req_op / c1_req_op  input  1  0 = read, 1 = write.
REQ-008 c0_req_addr / c1_req_addr  input  32  byte address.
REQ-009 c0_req_wdata / c1_req_wdata  input  32  write data.
REQ-010 c0_req_opaq / c1_req_opaq  input  p_opaq_bits  client tag.
REQ-011 c0_resp_val / c1_resp_val  output  1  response valid to client.
REQ-012 c0_resp_rdy / c1_resp_rdy  input  1  client ready for response.
REQ-013 c0_resp_data / c1_resp_data  output  32  read data (don't-care for writes).
REQ-014 c0_resp_opaq / c1_resp_opaq  output  p_opaq_bits  returned tag.
REQ-015 m_req_val / m_req_rdy / m_req_op / m_req_addr / m_req_wdata / m_req_opaq  out/in/out/out/out/out  1/1/1/32/32/p_opaq_bits  server request port.
REQ-016 m_resp_val / m_resp_rdy / m_resp_data / m_resp_opaq  in/out/in/in  1/1/32/p_opaq_bits  server response port; server returns responses in request order.

Function
REQ-017 Arbitration SHALL be round-robin: pointer last_gnt (1 bit); when both clients valid, grant the client != last_gnt; when one valid, grant it.
REQ-018 last_gnt SHALL update to the granted client id only on a request fire (m_req_val & m_req_rdy).
REQ-019 m_req_val SHALL equal (c0_req_val | c1_req_val) & !full; m_req_op/addr/wdata/opaq SHALL be the granted client's fields, combinationally, zero added latency.
REQ-020 ci_req_rdy SHALL equal gnt_i & m_req_rdy & !full; the non-granted client's rdy SHALL be 0.
REQ-021 A source-id FIFO of depth p_max_in_flight SHALL push the granted id on each request fire; count width clog2(p_max_in_flight+1); full = (count == p_max_in_flight), empty = (count == 0).
REQ-022 Full SHALL block new requests even if a response pops in the same cycle (no full bypass).
REQ-023 Response routing: head = FIFO head id; ci_resp_val = m_resp_val & !empty & (head == i); ci_resp_data/opaq = m_resp_data/opaq for both clients.
REQ-024 m_resp_rdy SHALL equal !empty & c<head>_resp_rdy; FIFO SHALL pop on m_resp_val & m_resp_rdy.
REQ-025 Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance, write and read pointers wrap modulo p_max_in_flight.
REQ-026 m_resp_val while empty is a server protocol error; block SHALL hold m_resp_rdy = 0 and assert no client resp_val.
REQ-027 A client SHALL hold req_val and fields stable until fire; the arbiter MAY change grant between cycles without a fire.

Reset
REQ-028 While rst is high: last_gnt = 1, FIFO pointers and count = 0; m_req_val, c0/c1_req_rdy, c0/c1_resp_val, m_resp_rdy SHALL be forced 0.
REQ-029 Reset mid-operation SHALL discard all in-flight tracking; the server SHALL be reset together with this block.
REQ-030 First cycle after reset with both clients valid SHALL grant client 0.

Verification
REQ-031 Both valid continuously, m_req_rdy = 1, responses returned 1 cycle later -> grants alternate 0,1,0,1; each response reaches the issuing client with matching opaq.
REQ-032 Only c1 valid for 4 requests, m_resp_val held 0 -> 4 fires, then m_req_val = 0 and c1_req_rdy = 0 (full, p_max_in_flight = 4).
REQ-033 Full, one response popped with c1 still valid the same cycle -> no request fire that cycle; fire on the next cycle.
REQ-034 Head id = 0, c0_resp_rdy = 0, c1_resp_rdy = 1, m_resp_val = 1 -> m_resp_rdy = 0, c1_resp_val = 0, FIFO unchanged until c0_resp_rdy rises.
REQ-035 7 requests with interleaved responses -> pointers wrap past 3 with ids and ordering preserved; count never exceeds 4.
REQ-036 rst asserted asynchronously with 2 in flight -> outputs of REQ-028 go 0 before next clock edge; after release both valid -> client 0 granted.

Source files
------------

// File: rtl/mem_arb2_if.sv
// Request/response handshake bundle shared by the two clients and the server port.
// "master" drives requests and accepts responses; "slave" is the opposite side.
interface mem_arb2_if #(
  parameter int p_opaq_bits = 8
);
  logic                   req_val;
  logic                   req_rdy;
  logic                   req_op;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic [p_opaq_bits-1:0] req_opaq;
  logic                   resp_val;
  logic                   resp_rdy;
  logic [31:0]            resp_data;
  logic [p_opaq_bits-1:0] resp_opaq;

  modport master (
    output req_val, req_op, req_addr, req_wdata, req_opaq, resp_rdy,
    input  req_rdy, resp_val, resp_data, resp_opaq
  );

  modport slave (
    input  req_val, req_op, req_addr, req_wdata, req_opaq, resp_rdy,
    output req_rdy, resp_val, resp_data, resp_opaq
  );
endinterface

// File: rtl/mem_arb2.sv
// Two-client round-robin memory arbiter; a source-id FIFO routes the in-order
// server responses back to the client that issued each request.
module mem_arb2 #(
  parameter int p_opaq_bits     = 8,
  parameter int p_max_in_flight = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb2_if.slave  c0,
  mem_arb2_if.slave  c1,
  mem_arb2_if.master m
);
  localparam int p_ptr_bits = $clog2(p_max_in_flight);
  localparam int p_cnt_bits = $clog2(p_max_in_flight + 1);
  localparam logic [p_cnt_bits-1:0] c_full_count = p_cnt_bits'(p_max_in_flight);

  logic                   last_gnt;
  logic                   gnt0;
  logic                   gnt1;
  logic                   full;
  logic                   empty;
  logic                   req_fire;
  logic                   resp_fire;
  logic                   head;
  logic [p_opaq_bits-1:0] gnt_opaq;

  logic                   id_mem [p_max_in_flight];
  logic [p_ptr_bits-1:0]  wr_ptr;
  logic [p_ptr_bits-1:0]  rd_ptr;
  logic [p_cnt_bits-1:0]  count;
  logic [p_cnt_bits-1:0]  count_nxt;

  // Round robin: on contention the client that did not win last time goes.
  assign gnt0 = c0.req_val & (~c1.req_val | last_gnt);
  assign gnt1 = c1.req_val & (~c0.req_val | ~last_gnt);

  assign full  = (count == c_full_count);
  assign empty = (count == '0);
  assign head  = id_mem[rd_ptr];

  // Request path: grant mux is purely combinational, no added latency.
  assign gnt_opaq    = gnt1 ? c1.req_opaq : c0.req_opaq;
  assign m.req_val   = ~rst & (c0.req_val | c1.req_val) & ~full;
  assign m.req_op    = gnt1 ? c1.req_op    : c0.req_op;
  assign m.req_addr  = gnt1 ? c1.req_addr  : c0.req_addr;
  assign m.req_wdata = gnt1 ? c1.req_wdata : c0.req_wdata;
  assign m.req_opaq  = gnt_opaq;
  assign c0.req_rdy  = ~rst & gnt0 & m.req_rdy & ~full;
  assign c1.req_rdy  = ~rst & gnt1 & m.req_rdy & ~full;
  assign req_fire    = m.req_val & m.req_rdy;

  // Response path: a response arriving with nothing in flight is never accepted.
  assign c0.resp_val  = ~rst & m.resp_val & ~empty & ~head;
  assign c1.resp_val  = ~rst & m.resp_val & ~empty &  head;
  assign c0.resp_data = m.resp_data;
  assign c1.resp_data = m.resp_data;
  assign c0.resp_opaq = m.resp_opaq;
  assign c1.resp_opaq = m.resp_opaq;
  assign m.resp_rdy   = ~rst & ~empty & (head ? c1.resp_rdy : c0.resp_rdy);
  assign resp_fire    = m.resp_val & m.resp_rdy;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({req_fire, resp_fire})
      2'b10:   count_nxt = count + p_cnt_bits'(1);
      2'b01:   count_nxt = count - p_cnt_bits'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (req_fire) begin
        last_gnt <= gnt1;
        wr_ptr   <= wr_ptr + p_ptr_bits'(1);
      end
      if (resp_fire) begin
        rd_ptr <= rd_ptr + p_ptr_bits'(1);
      end
      count <= count_nxt;
    end
  end

  // NOTE: the id storage is not reset; entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      id_mem[wr_ptr] <= gnt1;
    end
  end
endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: an in-order server model, per-client expected
// response queues and a grant-order queue checked by an independent monitor.
module tb_mem_arb2;
  localparam logic [31:0] c_key = 32'h5A5A_0F0F;

  typedef struct {
    logic [7:0]  opaq;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  opaq;
    logic [31:0] addr;
  } srv_t;

  logic clk;
  logic rst;

  mem_arb2_if #(.p_opaq_bits(8)) c0_if ();
  mem_arb2_if #(.p_opaq_bits(8)) c1_if ();
  mem_arb2_if #(.p_opaq_bits(8)) m_if ();

  mem_arb2 #(.p_opaq_bits(8), .p_max_in_flight(4)) dut (
    .clk (clk),
    .rst (rst),
    .c0  (c0_if),
    .c1  (c1_if),
    .m   (m_if)
  );

  int   n_cmp;
  int   n_err;
  int   srv_budget;
  bit   srv_bogus;
  int   max_q;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  srv_t srv_q[$];
  int   gq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put_req(input int c, input int seq);
    logic [7:0]  op;
    logic [31:0] a;
    exp_t        e;
    op     = {c[0], 7'(seq)};
    a      = 32'h1000_0000 + 32'(c * 256 + seq * 4);
    e.opaq = op;
    e.data = a ^ c_key;
    if (c == 0) begin
      c0_if.req_val = 1'b1; c0_if.req_op = 1'b0; c0_if.req_addr = a;
      c0_if.req_wdata = ~a; c0_if.req_opaq = op;
      exp_q0.push_back(e);
    end else begin
      c1_if.req_val = 1'b1; c1_if.req_op = 1'b0; c1_if.req_addr = a;
      c1_if.req_wdata = ~a; c1_if.req_opaq = op;
      exp_q1.push_back(e);
    end
  endtask

  task automatic drop(input int c);
    if (c == 0) c0_if.req_val = 1'b0;
    else        c1_if.req_val = 1'b0;
  endtask

  // Waits (bounded) for the client's request to fire; returns at posedge+1.
  task automatic wait_fire(input int c, input string name);
    bit fired;
    fired = 1'b0;
    for (int i = 0; i < 50 && !fired; i++) begin
      @(negedge clk);
      fired = (c == 0) ? (c0_if.req_val && c0_if.req_rdy) : (c1_if.req_val && c1_if.req_rdy);
    end
    check(name, 32'(fired), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive_client(input int c, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      put_req(c, base + k);
      wait_fire(c, (c == 0) ? "c0_fire" : "c1_fire");
    end
    drop(c);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // In-order server: one-cycle response latency, responses gated by a budget.
  initial begin : server
    srv_t        s;
    bit          rf;
    bit          pf;
    logic [7:0]  ro;
    logic [31:0] ra;
    m_if.resp_val  = 1'b0;
    m_if.resp_data = '0;
    m_if.resp_opaq = '0;
    max_q          = 0;
    forever begin
      @(negedge clk);
      rf = m_if.req_val && m_if.req_rdy;
      ro = m_if.req_opaq;
      ra = m_if.req_addr;
      pf = m_if.resp_val && m_if.resp_rdy;
      @(posedge clk); #1;
      if (rst) begin
        srv_q.delete();
      end else begin
        if (pf && srv_q.size() > 0) begin
          s = srv_q.pop_front();
          srv_budget--;
        end
        if (rf) begin
          s.opaq = ro;
          s.addr = ra;
          srv_q.push_back(s);
        end
        if (srv_q.size() > max_q) max_q = srv_q.size();
      end
      if (srv_bogus) begin
        m_if.resp_val  = 1'b1;
        m_if.resp_data = 32'hDEAD_BEEF;
        m_if.resp_opaq = 8'hFF;
      end else if (srv_budget > 0 && srv_q.size() > 0) begin
        m_if.resp_val  = 1'b1;
        m_if.resp_data = srv_q[0].addr ^ c_key;
        m_if.resp_opaq = srv_q[0].opaq;
      end else begin
        m_if.resp_val  = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (c0_if.resp_val && c0_if.resp_rdy) begin
          if (exp_q0.size() == 0) check("c0_resp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q0.pop_front();
            check("c0_resp_data", c0_if.resp_data, e.data);
            check("c0_resp_opaq", 32'(c0_if.resp_opaq), 32'(e.opaq));
          end
        end
        if (c1_if.resp_val && c1_if.resp_rdy) begin
          if (exp_q1.size() == 0) check("c1_resp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q1.pop_front();
            check("c1_resp_data", c1_if.resp_data, e.data);
            check("c1_resp_opaq", 32'(c1_if.resp_opaq), 32'(e.opaq));
          end
        end
        if (m_if.req_val && m_if.req_rdy && gq.size() > 0)
          check("grant_order", 32'(c1_if.req_rdy), 32'(gq.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    n_cmp = 0; n_err = 0; srv_budget = 1000; srv_bogus = 1'b1;
    rst = 1'b1;
    c0_if.req_val = 1'b1; c0_if.req_op = 1'b0; c0_if.req_addr = '0;
    c0_if.req_wdata = '0; c0_if.req_opaq = '0; c0_if.resp_rdy = 1'b1;
    c1_if.req_val = 1'b1; c1_if.req_op = 1'b0; c1_if.req_addr = '0;
    c1_if.req_wdata = '0; c1_if.req_opaq = '0; c1_if.resp_rdy = 1'b1;
    m_if.req_rdy = 1'b1;

    // Reset forces every handshake output low despite active inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_req_val", 32'(m_if.req_val), 32'd0);
    check("rst_c0_req_rdy", 32'(c0_if.req_rdy), 32'd0);
    check("rst_c1_req_rdy", 32'(c1_if.req_rdy), 32'd0);
    check("rst_c0_resp_val", 32'(c0_if.resp_val), 32'd0);
    check("rst_c1_resp_val", 32'(c1_if.resp_val), 32'd0);
    check("rst_m_resp_rdy", 32'(m_if.resp_rdy), 32'd0);
    srv_bogus = 1'b0;
    drop(0); drop(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both clients continuously valid: grants alternate starting with client 0.
    gq = '{0, 1, 0, 1, 0, 1};
    fork
      drive_client(0, 3, 0);
      drive_client(1, 3, 0);
    join
    wait_drain("t1_drain");
    check("t1_grants_seen", 32'(gq.size()), 32'd0);

    // Client 1 alone with no responses: four fires, then full blocks it.
    @(negedge clk); srv_budget = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      put_req(1, 10 + k);
      wait_fire(1, "t2_fire");
    end
    put_req(1, 14);
    @(negedge clk);
    check("t2_inflight", 32'(srv_q.size()), 32'd4);
    check("t2_full_m_req_val", 32'(m_if.req_val), 32'd0);
    check("t2_full_c1_req_rdy", 32'(c1_if.req_rdy), 32'd0);
    srv_budget = 1;
    @(negedge clk);
    check("t2_pop_m_resp_val", 32'(m_if.resp_val), 32'd1);
    check("t2_pop_m_resp_rdy", 32'(m_if.resp_rdy), 32'd1);
    check("t2_no_bypass_rdy", 32'(c1_if.req_rdy), 32'd0);
    check("t2_no_bypass_val", 32'(m_if.req_val), 32'd0);
    @(negedge clk);
    check("t2_fire_after_pop", 32'(c1_if.req_rdy), 32'd1);
    @(posedge clk); #1;
    drop(1);
    @(negedge clk); srv_budget = 1000;
    wait_drain("t2_drain");

    // Head belongs to client 0 which is not ready: response must wait.
    @(negedge clk); srv_budget = 0;
    @(posedge clk); #1;
    put_req(0, 20); wait_fire(0, "t3_fire0"); drop(0);
    put_req(1, 21); wait_fire(1, "t3_fire1"); drop(1);
    c0_if.resp_rdy = 1'b0;
    @(negedge clk); srv_budget = 1000;
    @(negedge clk);
    check("t3_m_resp_val", 32'(m_if.resp_val), 32'd1);
    check("t3_m_resp_rdy", 32'(m_if.resp_rdy), 32'd0);
    check("t3_c1_resp_val", 32'(c1_if.resp_val), 32'd0);
    check("t3_c0_resp_val", 32'(c0_if.resp_val), 32'd1);
    @(negedge clk);
    check("t3_hold_m_resp_rdy", 32'(m_if.resp_rdy), 32'd0);
    check("t3_hold_c0_resp_val", 32'(c0_if.resp_val), 32'd1);
    @(posedge clk); #1;
    c0_if.resp_rdy = 1'b1;
    wait_drain("t3_drain");

    // Seven interleaved requests across the pointer wrap.
    gq = '{0, 1, 0, 1, 0, 1, 0};
    fork
      drive_client(0, 4, 30);
      drive_client(1, 3, 40);
    join
    wait_drain("t4_drain");
    check("t4_grants_seen", 32'(gq.size()), 32'd0);
    check("max_in_flight_le4", 32'(max_q <= 4), 32'd1);

    // Spurious server response while nothing is in flight.
    @(negedge clk); srv_bogus = 1'b1;
    @(negedge clk);
    check("t5_m_resp_val", 32'(m_if.resp_val), 32'd1);
    check("t5_m_resp_rdy", 32'(m_if.resp_rdy), 32'd0);
    check("t5_c0_resp_val", 32'(c0_if.resp_val), 32'd0);
    check("t5_c1_resp_val", 32'(c1_if.resp_val), 32'd0);
    srv_bogus = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset with two requests in flight.
    @(negedge clk); srv_budget = 0;
    @(posedge clk); #1;
    put_req(0, 50); wait_fire(0, "t6_fire0"); drop(0);
    put_req(1, 51); wait_fire(1, "t6_fire1"); drop(1);
    @(negedge clk); srv_budget = 1;
    @(posedge clk); #2;
    c0_if.req_val = 1'b1;
    c1_if.req_val = 1'b1;
    #1;
    check("t6_pre_c0_resp_val", 32'(c0_if.resp_val), 32'd1);
    check("t6_pre_m_req_val", 32'(m_if.req_val), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_m_req_val", 32'(m_if.req_val), 32'd0);
    check("t6_rst_c0_req_rdy", 32'(c0_if.req_rdy), 32'd0);
    check("t6_rst_c1_req_rdy", 32'(c1_if.req_rdy), 32'd0);
    check("t6_rst_c0_resp_val", 32'(c0_if.resp_val), 32'd0);
    check("t6_rst_c1_resp_val", 32'(c1_if.resp_val), 32'd0);
    check("t6_rst_m_resp_rdy", 32'(m_if.resp_rdy), 32'd0);
    drop(0); drop(1);
    exp_q0.delete(); exp_q1.delete(); gq.delete();
    srv_budget = 1000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    gq = '{0, 1};
    put_req(0, 60);
    put_req(1, 61);
    @(negedge clk);
    check("t6_first_gnt_c0", 32'(c0_if.req_rdy), 32'd1);
    check("t6_first_gnt_c1", 32'(c1_if.req_rdy), 32'd0);
    @(posedge clk); #1;
    drop(0);
    wait_fire(1, "t6_fire_c1_after");
    drop(1);
    wait_drain("t6_drain");
    check("t6_grants_seen", 32'(gq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
